calc_rpn: RTL and testbench

CALC_RPN -- requirements
Module: calc_rpn

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_alu.sv | 33 +++
 rtl/calc_rpn.sv | 195 +++++++++++++++++++
 tb/tb_calc_rpn.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator: ALU op codes and controller states.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_LSR  = 3'b000,
        OP_LSL  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MULT = 3'b100,
        OP_NOR  = 3'b101,
        OP_NAND = 3'b110,
        OP_XOR  = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } calc_state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the single-cycle ops; MULT is sequenced by the caller.
// Ports: a (next-on-stack), b (top-of-stack), op (operation), y (result).
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] y
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_LSR:  y = a >> shamt;
            OP_LSL:  y = a << shamt;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_NOR:  y = ~(a | b);
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/calc_rpn.sv
// RPN calculator: operand stack with push/execute/clear buttons and a
// shift-add multiplier taking WIDTH cycles.
// Ports: clk, rst_n (async low); btnac clear, btnc push, btnu execute;
// {btnl,btnr,btnd} op select; sw operand; led TOS; depth count;
// empty/full flags; busy (multiply running); err (sticky error).
module calc_rpn
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btnac,
    input  logic                       btnc,
    input  logic                       btnu,
    input  logic                       btnl,
    input  logic                       btnr,
    input  logic                       btnd,
    input  logic [WIDTH-1:0]           sw,
    output logic [WIDTH-1:0]           led,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(WIDTH);

    calc_state_t state, state_d;

    logic btnac_q, btnc_q, btnu_q;
    logic ac_p, c_p, u_p;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [IW-1:0]    tos_idx, nos_idx, wr_idx;
    logic [WIDTH-1:0] tos, nos, wr_data, alu_y;
    logic             wr_en;

    logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
    logic [CW-1:0]    cnt;
    logic             mul_start, mul_step;

    logic [DW-1:0]    depth_d;
    logic [WIDTH-1:0] led_d;
    logic             err_d, busy_d;

    alu_op_t op;

    assign op   = alu_op_t'({btnl, btnr, btnd});
    assign ac_p = btnac & ~btnac_q;
    assign c_p  = btnc & ~btnc_q;
    assign u_p  = btnu & ~btnu_q;

    assign tos_idx = IW'(depth - DW'(1));
    assign nos_idx = IW'(depth - DW'(2));
    assign tos     = stack[tos_idx];
    assign nos     = stack[nos_idx];

    // One shift-add step: accumulate the multiplicand when the current multiplier bit is set.
    assign acc_nx = acc + (mplier[0] ? mcand : '0);

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (nos),
        .b  (tos),
        .op (op),
        .y  (alu_y)
    );

    // Button edge-detect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btnac_q <= 1'b0;
            btnc_q  <= 1'b0;
            btnu_q  <= 1'b0;
        end else begin
            btnac_q <= btnac;
            btnc_q  <= btnc;
            btnu_q  <= btnu;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            depth <= '0;
            led   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            state <= state_d;
            depth <= depth_d;
            led   <= led_d;
            err   <= err_d;
            busy  <= busy_d;
            empty <= (depth_d == '0);
            full  <= (depth_d == DW'(DEPTH));
        end
    end

    // Stack storage; contents are don't-care above depth so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) stack[wr_idx] <= wr_data;
    end

    // Multiplier datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_start) begin
            mcand  <= nos;
            mplier <= tos;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nx;
            cnt    <= cnt + CW'(1);
        end
    end

    // Next-state and control decode; btnac outranks btnu, which outranks btnc.
    always_comb begin
        state_d   = state;
        depth_d   = depth;
        led_d     = led;
        err_d     = err;
        busy_d    = busy;
        wr_en     = 1'b0;
        wr_idx    = nos_idx;
        wr_data   = alu_y;
        mul_start = 1'b0;
        mul_step  = 1'b0;

        if (ac_p) begin
            state_d = IDLE;
            depth_d = '0;
            led_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (u_p) begin
                        if (depth < DW'(2)) begin
                            err_d = 1'b1;
                        end else if (op == OP_MULT) begin
                            state_d   = MUL;
                            busy_d    = 1'b1;
                            mul_start = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            depth_d = depth - DW'(1);
                            led_d   = alu_y;
                        end
                    end else if (c_p) begin
                        if (depth == DW'(DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_idx  = IW'(depth);
                            wr_data = sw;
                            depth_d = depth + DW'(1);
                            led_d   = sw;
                        end
                    end
                end
                MUL: begin
                    mul_step = 1'b1;
                    // Final step: write the product in place of A/B on this edge.
                    if (cnt == CW'(WIDTH - 1)) begin
                        wr_en   = 1'b1;
                        wr_data = acc_nx;
                        depth_d = depth - DW'(1);
                        led_d   = acc_nx;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_rpn.sv
// Self-checking bench for calc_rpn (WIDTH=16, DEPTH=8): table of op vectors
// plus directed sequences for overflow, underflow, held buttons, priority,
// busy behaviour, abort and reset during a multiply.
module tb_calc_rpn;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnac = 1'b0, btnc = 1'b0, btnu = 1'b0;
    logic        btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] led;
    logic [3:0]  depth;
    logic        empty, full, busy, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    calc_rpn #(.WIDTH(16), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btnac (btnac),
        .btnc  (btnc),
        .btnu  (btnu),
        .btnl  (btnl),
        .btnr  (btnr),
        .btnd  (btnd),
        .sw    (sw),
        .led   (led),
        .depth (depth),
        .empty (empty),
        .full  (full),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle press followed by one released cycle
    task automatic push(input logic [15:0] v);
        sw = v;
        btnc = 1'b1;
        step();
        btnc = 1'b0;
        step();
    endtask

    task automatic clear();
        btnac = 1'b1;
        step();
        btnac = 1'b0;
        step();
    endtask

    // Execute pulse; returns just after the commit edge
    task automatic exec(input logic [2:0] op);
        {btnl, btnr, btnd} = op;
        btnu = 1'b1;
        step();
        btnu = 1'b0;
    endtask

    // Counts cycles busy is observed high, bounded
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
        end
        if (n >= 64) begin
            errors++;
            $display("FAIL busy_timeout: got %0d expected <64", n);
        end
    endtask

    initial begin
        int n;

        vecs[0]  = '{16'h8000, 16'h0003, 3'b000, 16'h1000};
        vecs[1]  = '{16'h8000, 16'h0013, 3'b000, 16'h1000};
        vecs[2]  = '{16'h00ff, 16'h0004, 3'b001, 16'h0ff0};
        vecs[3]  = '{16'hffff, 16'h0002, 3'b010, 16'h0001};
        vecs[4]  = '{16'h0001, 16'h0002, 3'b011, 16'hffff};
        vecs[5]  = '{16'hf0f0, 16'h0ff0, 3'b101, 16'h000f};
        vecs[6]  = '{16'hff00, 16'h0ff0, 3'b110, 16'hf0ff};
        vecs[7]  = '{16'h285a, 16'h04c8, 3'b111, 16'h2c92};
        vecs[8]  = '{16'h5e1a, 16'h07fe, 3'b100, 16'h13cc};
        vecs[9]  = '{16'h0003, 16'h0005, 3'b100, 16'h000f};
        vecs[10] = '{16'hffff, 16'hffff, 3'b100, 16'h0001};

        repeat (3) step();
        check("rst_led", 32'(led), 32'h0);
        check("rst_depth", 32'(depth), 32'h0);
        check("rst_flags", 32'({empty, full, busy, err}), 32'b1000);
        rst_n = 1'b1;
        step();

        // Table-driven ops
        foreach (vecs[i]) begin
            clear();
            push(vecs[i].a);
            push(vecs[i].b);
            exec(vecs[i].op);
            if (vecs[i].op == 3'b100) begin
                check($sformatf("v%0d_led_busy", i), 32'(led), 32'(vecs[i].b));
                check($sformatf("v%0d_depth_busy", i), 32'(depth), 32'd2);
                wait_busy(n);
                check($sformatf("v%0d_busy_cycles", i), 32'(n), 32'd16);
            end else begin
                check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            end
            check($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp));
            check($sformatf("v%0d_depth", i), 32'(depth), 32'd1);
            check($sformatf("v%0d_err", i), 32'(err), 32'd0);
            step();
        end

        // Overflow then clear
        clear();
        for (int v = 1; v <= 9; v++) push(16'(v));
        check("ovf_depth", 32'(depth), 32'd8);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_led", 32'(led), 32'h8);
        check("ovf_err", 32'(err), 32'd1);
        clear();
        check("clr_depth", 32'(depth), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        check("clr_led", 32'(led), 32'h0);
        check("clr_empty", 32'(empty), 32'd1);

        // Underflow
        push(16'hc7bf);
        exec(3'b011);
        check("unf_err", 32'(err), 32'd1);
        check("unf_depth", 32'(depth), 32'd1);
        check("unf_led", 32'(led), 32'hc7bf);
        step();

        // Held push acts once
        clear();
        sw = 16'h0005;
        btnc = 1'b1;
        repeat (5) step();
        btnc = 1'b0;
        step();
        check("held_depth", 32'(depth), 32'd1);
        check("held_led", 32'(led), 32'h5);

        // Priority: execute beats push on the same edge
        push(16'h0002);
        sw = 16'h0009;
        {btnl, btnr, btnd} = 3'b010;
        btnu = 1'b1;
        btnc = 1'b1;
        step();
        btnu = 1'b0;
        btnc = 1'b0;
        check("prio_u_depth", 32'(depth), 32'd1);
        check("prio_u_led", 32'(led), 32'h7);
        step();
        // Clear beats push on the same edge
        btnac = 1'b1;
        btnc = 1'b1;
        step();
        btnac = 1'b0;
        btnc = 1'b0;
        check("prio_ac_depth", 32'(depth), 32'd0);
        step();

        // Presses ignored while busy
        push(16'h0003);
        push(16'h0005);
        exec(3'b100);
        step();
        push(16'h0077);
        exec(3'b010);
        check("busy_ign_depth", 32'(depth), 32'd2);
        check("busy_ign_led", 32'(led), 32'h5);
        check("busy_ign_err", 32'(err), 32'd0);
        check("busy_ign_busy", 32'(busy), 32'd1);
        wait_busy(n);
        check("busy_ign_res", 32'(led), 32'h000f);
        check("busy_ign_depth2", 32'(depth), 32'd1);

        // Abort multiply with clear
        clear();
        push(16'h0003);
        push(16'h0005);
        exec(3'b100);
        repeat (4) step();
        clear();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_depth", 32'(depth), 32'd0);
        repeat (20) step();
        check("abort_nowrite", 32'(depth), 32'd0);

        // Reset mid-multiply, push held across reset release
        push(16'h5e1a);
        push(16'h07fe);
        exec(3'b100);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("mrst_led", 32'(led), 32'h0);
        check("mrst_depth", 32'(depth), 32'h0);
        check("mrst_flags", 32'({empty, full, busy, err}), 32'b1000);
        sw = 16'h0004;
        btnc = 1'b1;
        repeat (8) step();
        rst_n = 1'b1;
        step();
        btnc = 1'b0;
        check("mrst_push_led", 32'(led), 32'h4);
        check("mrst_push_depth", 32'(depth), 32'd1);
        repeat (20) step();
        check("mrst_nowrite", 32'({depth, busy}), 32'({4'd1, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
